// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, light codes and request-flag bit positions
// shared by the traffic controller and its timer.
// Optional feature macro: TRAFFIC_CTRL_ARROW_EN (left-turn arrow phases).
package traffic_pkg;

  typedef enum logic [3:0] {
    MAIN_GO          = 4'd0,
    MAIN_WAIT        = 4'd1,
    RED_1            = 4'd2,
    CROSS_GO         = 4'd3,
    CROSS_WAIT       = 4'd4,
    RED_2            = 4'd5
`ifdef TRAFFIC_CTRL_ARROW_EN
    ,
    CROSS_ARROW_GO   = 4'd6,
    CROSS_ARROW_WAIT = 4'd7,
    MAIN_ARROW_GO    = 4'd8,
    MAIN_ARROW_WAIT  = 4'd9
`endif
  } phase_e;

  // Light codes: {red, yellow, green, yellow_arrow, green_arrow}
  localparam logic [4:0] LT_RED    = 5'b10000;
  localparam logic [4:0] LT_YELLOW = 5'b01000;
  localparam logic [4:0] LT_GREEN  = 5'b00100;
  localparam logic [4:0] LT_YARROW = 5'b00010;
  localparam logic [4:0] LT_GARROW = 5'b00001;

  // Request flag positions, identical to the sensors bit order
  localparam int REQ_LEFT_MAIN  = 0;
  localparam int REQ_LEFT_CROSS = 1;
  localparam int REQ_CROSS      = 2;
  localparam int REQ_WALK_MAIN  = 3;
  localparam int REQ_WALK_CROSS = 4;

`ifdef TRAFFIC_CTRL_ARROW_EN
  localparam logic [4:0] REQ_MASK = 5'b11111;
`else
  // Left-turn sensors have no phase to serve them, so they never latch
  localparam logic [4:0] REQ_MASK = 5'b11100;
`endif

endpackage

// File: rtl/phase_timer.sv
// phase_timer: one-second prescaler plus saturating seconds countdown.
// A load restarts the prescaler and sets the count to the new duration.
module phase_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int CNT_W     = 4,
  parameter int RESET_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] duration,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Prescaler wrap produces the tick; the count stops at zero
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (load) begin
      presc_d = '0;
      cnt_d   = duration;
    end else if (presc_q == PW'(TICK_DIV - 1)) begin
      presc_d = '0;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= CNT_W'(RESET_CNT);
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-approach intersection controller with sticky sensor
// requests, registered light/walk outputs and a seconds countdown display.
// Optional feature macro: TRAFFIC_CTRL_ARROW_EN adds left-turn arrow phases.
module traffic_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int CNT_W      = 4,
  parameter int GREEN_SEC  = 8,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 2,
  parameter int ARROW_SEC  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       sensors,
  output logic [4:0]       main_lights,
  output logic [4:0]       cross_lights,
  output logic             walk_main,
  output logic             walk_cross,
  output logic [CNT_W-1:0] count_out
);

  import traffic_pkg::*;

  phase_e           state_q, state_d;
  logic [4:0]       req_q, req_d, clr;
  logic [4:0]       main_lights_q, main_lights_d;
  logic [4:0]       cross_lights_q, cross_lights_d;
  logic             walk_main_q, walk_main_d;
  logic             walk_cross_q, walk_cross_d;
  logic             load, zero;
  logic [CNT_W-1:0] duration;

  function automatic logic [CNT_W-1:0] dur_of(input phase_e s);
    case (s)
      MAIN_GO, CROSS_GO:            dur_of = CNT_W'(GREEN_SEC);
      MAIN_WAIT, CROSS_WAIT:        dur_of = CNT_W'(YELLOW_SEC);
`ifdef TRAFFIC_CTRL_ARROW_EN
      CROSS_ARROW_GO, MAIN_ARROW_GO:     dur_of = CNT_W'(ARROW_SEC);
      CROSS_ARROW_WAIT, MAIN_ARROW_WAIT: dur_of = CNT_W'(YELLOW_SEC);
`endif
      default:                      dur_of = CNT_W'(ALLRED_SEC);
    endcase
  endfunction

  phase_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .RESET_CNT(ALLRED_SEC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .duration(duration),
    .count   (count_out),
    .zero    (zero)
  );

  // Next phase: timed exits at count zero, MAIN_GO waits for a request
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GO:
        if (zero && (req_q[REQ_CROSS] || req_q[REQ_WALK_MAIN] ||
                     req_q[REQ_LEFT_CROSS] || req_q[REQ_LEFT_MAIN]))
          state_d = MAIN_WAIT;
      MAIN_WAIT:  if (zero) state_d = RED_1;
`ifdef TRAFFIC_CTRL_ARROW_EN
      RED_1:      if (zero) state_d = req_q[REQ_LEFT_CROSS] ? CROSS_ARROW_GO : CROSS_GO;
      CROSS_ARROW_GO:   if (zero) state_d = CROSS_ARROW_WAIT;
      CROSS_ARROW_WAIT: if (zero) state_d = CROSS_GO;
      RED_2:      if (zero) state_d = req_q[REQ_LEFT_MAIN] ? MAIN_ARROW_GO : MAIN_GO;
      MAIN_ARROW_GO:    if (zero) state_d = MAIN_ARROW_WAIT;
      MAIN_ARROW_WAIT:  if (zero) state_d = MAIN_GO;
`else
      RED_1:      if (zero) state_d = CROSS_GO;
      RED_2:      if (zero) state_d = MAIN_GO;
`endif
      CROSS_GO:   if (zero) state_d = CROSS_WAIT;
      CROSS_WAIT: if (zero) state_d = RED_2;
      default:    state_d = RED_2;
    endcase
  end

  // Any phase change restarts the timer with the new phase's duration
  always_comb begin
    load     = (state_d != state_q);
    duration = dur_of(state_d);
  end

  // Requests clear on leaving their serving phase; a live sensor wins
  always_comb begin
    clr = '0;
    if (state_d != state_q) begin
      case (state_q)
        MAIN_GO:  clr[REQ_WALK_CROSS] = 1'b1;
        CROSS_GO: begin
          clr[REQ_CROSS]     = 1'b1;
          clr[REQ_WALK_MAIN] = 1'b1;
        end
`ifdef TRAFFIC_CTRL_ARROW_EN
        CROSS_ARROW_GO: clr[REQ_LEFT_CROSS] = 1'b1;
        MAIN_ARROW_GO:  clr[REQ_LEFT_MAIN]  = 1'b1;
`endif
        default: ;
      endcase
    end
    req_d = ((req_q & ~clr) | sensors) & REQ_MASK;
  end

  // Output decode from the next phase so outputs switch with the state
  always_comb begin
    main_lights_d  = LT_RED;
    cross_lights_d = LT_RED;
    case (state_d)
      MAIN_GO:          main_lights_d  = LT_GREEN;
      MAIN_WAIT:        main_lights_d  = LT_YELLOW;
      CROSS_GO:         cross_lights_d = LT_GREEN;
      CROSS_WAIT:       cross_lights_d = LT_YELLOW;
`ifdef TRAFFIC_CTRL_ARROW_EN
      CROSS_ARROW_GO:   cross_lights_d = LT_GARROW;
      CROSS_ARROW_WAIT: cross_lights_d = LT_YARROW;
      MAIN_ARROW_GO:    main_lights_d  = LT_GARROW;
      MAIN_ARROW_WAIT:  main_lights_d  = LT_YARROW;
`endif
      default: ;
    endcase
    // Walk is decided once at green entry and held for the whole green
    walk_main_d  = 1'b0;
    walk_cross_d = 1'b0;
    if (state_d == CROSS_GO)
      walk_main_d = (state_q == CROSS_GO) ? walk_main_q : req_q[REQ_WALK_MAIN];
    if (state_d == MAIN_GO)
      walk_cross_d = (state_q == MAIN_GO) ? walk_cross_q : req_q[REQ_WALK_CROSS];
  end

  // Phase, request and output registers; reset forces all-red at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RED_2;
      req_q          <= '0;
      main_lights_q  <= LT_RED;
      cross_lights_q <= LT_RED;
      walk_main_q    <= 1'b0;
      walk_cross_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      main_lights_q  <= main_lights_d;
      cross_lights_q <= cross_lights_d;
      walk_main_q    <= walk_main_d;
      walk_cross_q   <= walk_cross_d;
    end
  end

  assign main_lights  = main_lights_q;
  assign cross_lights = cross_lights_q;
  assign walk_main    = walk_main_q;
  assign walk_cross   = walk_cross_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: directed bench for traffic_ctrl with TICK_DIV=4.
// Arrow-phase steps are included when TRAFFIC_CTRL_ARROW_EN is defined.
module tb_traffic_ctrl;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic [4:0] sensors;
  logic [4:0] main_lights, cross_lights;
  logic       walk_main, walk_cross;
  logic [3:0] count_out;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] Y  = 5'b01000;
  localparam logic [4:0] G  = 5'b00100;
  localparam logic [4:0] YA = 5'b00010;
  localparam logic [4:0] GA = 5'b00001;
  localparam logic [4:0] Z  = 5'b00000;

  traffic_ctrl #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset       (reset),
    .sensors     (sensors),
    .main_lights (main_lights),
    .cross_lights(cross_lights),
    .walk_main   (walk_main),
    .walk_cross  (walk_cross),
    .count_out   (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at the negedge just after a phase was entered: checks lights and
  // loaded count, then measures the dwell until the lights change.
  task automatic phase(input string tag, input logic [4:0] m, input logic [4:0] c,
                       input int sec, input logic [4:0] pulse, input logic [4:0] hold);
    int n;
    n = 0;
    chk({tag, "/main"},  main_lights,  m);
    chk({tag, "/cross"}, cross_lights, c);
    chk({tag, "/count"}, count_out,    sec);
    sensors = pulse | hold;
    while (main_lights === m && cross_lights === c && n < 400) begin
      @(negedge clk);
      sensors = hold;
      n++;
    end
    chk({tag, "/dwell"}, n, sec * TD + 1);
  endtask

  initial begin
    reset   = 1'b1;
    sensors = '0;
    step(3);
    chk("rst/main",   main_lights,  R);
    chk("rst/cross",  cross_lights, R);
    chk("rst/count",  count_out,    2);
    chk("rst/walk_m", walk_main,    0);
    chk("rst/walk_c", walk_cross,   0);

    // Release: RED_2 then MAIN_GO resting with nothing requested
    reset = 1'b0;
    phase("red2_init", R, R, 2, Z, Z);
    chk("main_go/main",  main_lights, G);
    chk("main_go/count", count_out,   8);
    step(40);
    chk("rest/main",  main_lights,  G);
    chk("rest/cross", cross_lights, R);
    chk("rest/count", count_out,    0);

    // Round 1: cross traffic pulse while resting; left-turn sensors too in
    // the plain build, where they must have no effect
`ifdef TRAFFIC_CTRL_ARROW_EN
    sensors = 5'b00100;
`else
    sensors = 5'b00111;
`endif
    step(1);
    sensors = '0;
    step(1);
    phase("r1_main_wait", Y, R, 3, Z, Z);
    phase("r1_red1",      R, R, 2, Z, Z);
    chk("r1_cross_go/walk_m", walk_main, 0);
    phase("r1_cross_go",  R, G, 8, Z, Z);
    phase("r1_cross_wait", R, Y, 3, Z, Z);
    phase("r1_red2",      R, R, 2, Z, Z);

    // Round 2: walk-main pulse at MAIN_GO entry gives minimum green only;
    // walk-cross pulsed and walk-main held through the CROSS_GO exit
    chk("r2_main_go/walk_c", walk_cross, 0);
    phase("r2_main_go",   G, R, 8, 5'b01000, Z);
    phase("r2_main_wait", Y, R, 3, Z, Z);
    phase("r2_red1",      R, R, 2, Z, Z);
    chk("r2_cross_go/walk_m", walk_main, 1);
    phase("r2_cross_go",  R, G, 8, 5'b10000, 5'b01000);
    sensors = '0;
    chk("r2_cross_wait/walk_m", walk_main, 0);
    phase("r2_cross_wait", R, Y, 3, Z, Z);
    phase("r2_red2",      R, R, 2, Z, Z);

    // Round 3: walk-main flag survived, so MAIN_GO leaves at minimum green
    chk("r3_main_go/walk_c", walk_cross, 1);
    phase("r3_main_go",   G, R, 8, Z, Z);
    chk("r3_main_wait/walk_c", walk_cross, 0);
    phase("r3_main_wait", Y, R, 3, Z, Z);
    phase("r3_red1",      R, R, 2, Z, Z);
    chk("r3_cross_go/walk_m", walk_main, 1);
    phase("r3_cross_go",  R, G, 8, Z, Z);
    phase("r3_cross_wait", R, Y, 3, Z, Z);
    phase("r3_red2",      R, R, 2, Z, Z);
    chk("r3_main_go/walk_c2", walk_cross, 0);
    step(40);
    chk("r3_rest/main",  main_lights, G);
    chk("r3_rest/count", count_out,   0);

    // Round 4: asynchronous reset in the middle of CROSS_GO
    sensors = 5'b01100;
    step(1);
    sensors = '0;
    step(1);
    phase("r4_main_wait", Y, R, 3, Z, Z);
    phase("r4_red1",      R, R, 2, Z, Z);
    chk("r4_cross_go/cross",  cross_lights, G);
    chk("r4_cross_go/walk_m", walk_main,    1);
    step(10);
    #2 reset = 1'b1;
    #1;
    chk("r4_async/main",   main_lights,  R);
    chk("r4_async/cross",  cross_lights, R);
    chk("r4_async/count",  count_out,    2);
    chk("r4_async/walk_m", walk_main,    0);
    @(negedge clk);
    reset = 1'b0;
    phase("r4_red2", R, R, 2, Z, Z);
    chk("r4_main_go/main", main_lights, G);
    step(40);
    chk("r4_rest/main", main_lights, G);

`ifdef TRAFFIC_CTRL_ARROW_EN
    // Round 5: both left-turn requests; each arrow pair runs once
    sensors = 5'b00011;
    step(1);
    sensors = '0;
    step(1);
    phase("r5_main_wait",   Y,  R,  3, Z, Z);
    phase("r5_red1",        R,  R,  2, Z, Z);
    phase("r5_cross_arrow", R,  GA, 5, Z, Z);
    phase("r5_cross_aw",    R,  YA, 3, Z, Z);
    phase("r5_cross_go",    R,  G,  8, Z, Z);
    phase("r5_cross_wait",  R,  Y,  3, Z, Z);
    phase("r5_red2",        R,  R,  2, Z, Z);
    phase("r5_main_arrow",  GA, R,  5, Z, Z);
    phase("r5_main_aw",     YA, R,  3, Z, Z);
    chk("r5_main_go/main", main_lights, G);
    step(40);
    chk("r5_rest/main",  main_lights, G);
    chk("r5_rest/count", count_out,   0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
